hazard_scoreboard: RTL and testbench

//  Parametrised stall + forwarding controller for the 5-stage MIPS pipeline; takes decoded D-stage fields
//  (rs/rt, Tuse, A3, Tnew) instead of raw instructions and tracks in-flight producers in an internal
//  E/M/W shadow pipeline with per-slot Tnew countdown. Also owns the mult/div busy counter, so HI/LO

---
 rtl/hazard_scoreboard.sv | 91 +++++++++
 tb/tb_hazard_scoreboard.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: GPR/HI-LO stall and D/E/M forwarding control over E/M/W shadow slots; define FWD_W2D_EN for W->D forwarding
module hazard_scoreboard #(
   parameter int REG_W    = 5,
   parameter int TN_W     = 2,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [REG_W-1:0] d_rs,
   input  logic [REG_W-1:0] d_rt,
   input  logic [TN_W-1:0]  d_tuse_rs,
   input  logic [TN_W-1:0]  d_tuse_rt,
   input  logic [REG_W-1:0] d_a3,
   input  logic             d_wen,
   input  logic [TN_W-1:0]  d_tnew,
   input  logic             d_md_start,
   input  logic             d_md_div,
   input  logic             d_md_use,
   output logic             stall,
   output logic [1:0]       fwd_d_rs,
   output logic [1:0]       fwd_d_rt,
   output logic [1:0]       fwd_e_rs,
   output logic [1:0]       fwd_e_rt,
   output logic [1:0]       fwd_m_rt,
   output logic             md_start,
   output logic             md_busy
);
   typedef struct packed {
      logic             vld;
      logic [REG_W-1:0] a3;
      logic [TN_W-1:0]  tnew;
   } prod_t;
   localparam logic [TN_W-1:0] NO_USE = TN_W'(3);
   prod_t d_p, e_p, m_p, w_p, wd_p;
   logic [REG_W-1:0] e_rs, e_rt, m_rt;
   logic e_md, e_div;
   logic [CNT_W-1:0] cnt;
   function automatic prod_t age(prod_t p);
      prod_t q;
      q = p;
      q.tnew = (p.tnew == '0) ? '0 : p.tnew - TN_W'(1);
      return q;
   endfunction
   // nearest matching producer decides: its code if ready, otherwise 0 (stall covers it)
   function automatic logic [1:0] pick(prod_t p, logic [1:0] code, logic [REG_W-1:0] s, logic [1:0] older);
      return (p.vld && p.a3 == s) ? ((p.tnew == '0) ? code : 2'd0) : older;
   endfunction
   function automatic logic late(prod_t p, logic [REG_W-1:0] s, logic [TN_W-1:0] u);
      return p.vld && p.a3 == s && p.tnew > u && u != NO_USE;
   endfunction
   assign d_p = '{vld: d_wen && d_a3 != '0, a3: d_a3, tnew: d_tnew};
`ifdef FWD_W2D_EN
   assign wd_p = w_p;
`else
   assign wd_p = '0;
`endif
   assign md_start = e_md;
   assign md_busy  = cnt != '0;
   assign stall = late(e_p, d_rs, d_tuse_rs) || late(m_p, d_rs, d_tuse_rs) ||
                  late(e_p, d_rt, d_tuse_rt) || late(m_p, d_rt, d_tuse_rt) ||
                  (d_md_use && (md_start || md_busy));
   assign fwd_d_rs = pick(e_p, 2'd1, d_rs, pick(m_p, 2'd2, d_rs, pick(wd_p, 2'd3, d_rs, 2'd0)));
   assign fwd_d_rt = pick(e_p, 2'd1, d_rt, pick(m_p, 2'd2, d_rt, pick(wd_p, 2'd3, d_rt, 2'd0)));
   assign fwd_e_rs = pick(m_p, 2'd2, e_rs, pick(w_p, 2'd3, e_rs, 2'd0));
   assign fwd_e_rt = pick(m_p, 2'd2, e_rt, pick(w_p, 2'd3, e_rt, 2'd0));
   assign fwd_m_rt = pick(w_p, 2'd3, m_rt, 2'd0);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         e_p   <= '0;
         m_p   <= '0;
         w_p   <= '0;
         e_rs  <= '0;
         e_rt  <= '0;
         m_rt  <= '0;
         e_md  <= 1'b0;
         e_div <= 1'b0;
         cnt   <= '0;
      end else begin
         e_p   <= stall ? '0 : d_p;
         e_rs  <= stall ? '0 : d_rs;
         e_rt  <= stall ? '0 : d_rt;
         e_md  <= !stall && d_md_start;
         e_div <= !stall && d_md_start && d_md_div;
         m_p   <= age(e_p);
         m_rt  <= e_rt;
         w_p   <= age(m_p);
         cnt   <= md_start ? (e_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT)) : md_busy ? cnt - CNT_W'(1) : cnt;
      end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed MIPS hazard cases plus random instruction streams against an age-based reference model
module tb_hazard_scoreboard;
   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;
`ifdef FWD_W2D_EN
   localparam int DK = 2;
`else
   localparam int DK = 1;
`endif
   typedef struct packed {
      logic [4:0] rs, rt, a3;
      logic [1:0] ur, ut, tnew;
      logic       wen, md, dv, mu;
   } ins_t;
   typedef struct packed {
      logic       stall;
      logic [1:0] fdrs, fdrt, fers, fert, fmrt;
      logic       mds, mdb;
   } exp_t;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic [4:0] d_rs, d_rt, d_a3;
   logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
   logic d_wen, d_md_start, d_md_div, d_md_use;
   logic stall, md_start, md_busy;
   logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
   ins_t hist [3];
   ins_t prog [$];
   ins_t cur;
   logic cur_prog;
   exp_t eq [$];
   exp_t last;
   int cyc = 0;
   int md_at = -100;
   int md_lat = 0;
   int tests = 0;
   int fails = 0;
   hazard_scoreboard dut (
      .clk(clk), .reset_n(reset_n), .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
      .d_a3(d_a3), .d_wen(d_wen), .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
      .d_md_use(d_md_use), .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs),
      .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt), .md_start(md_start), .md_busy(md_busy)
   );
   always #5 clk = ~clk;
   function automatic ins_t mk(int rs, int rt, int ur, int ut, int a3, int wen, int tnew, int md, int dv, int mu);
      ins_t x;
      x.rs = 5'(rs); x.rt = 5'(rt); x.ur = 2'(ur); x.ut = 2'(ut); x.a3 = 5'(a3);
      x.wen = wen != 0; x.tnew = 2'(tnew); x.md = md != 0; x.dv = dv != 0; x.mu = mu != 0;
      return x;
   endfunction
   // instruction k stages past E entry still needs max(tnew-k,0) cycles for its result
   function automatic int rem(int k);
      return int'(hist[k].tnew) > k ? int'(hist[k].tnew) - k : 0;
   endfunction
   function automatic bit wr(int k, logic [4:0] s);
      return hist[k].wen && hist[k].a3 == s && s != 5'd0;
   endfunction
   function automatic logic [1:0] sel(logic [4:0] s, int lo, int hi, int base);
      for (int k = lo; k <= hi; k++)
         if (wr(k, s)) return rem(k) == 0 ? 2'(k + base) : 2'd0;
      return 2'd0;
   endfunction
   function automatic bit late(logic [4:0] s, logic [1:0] u);
      if (u == 2'd3) return 1'b0;
      for (int k = 0; k <= 1; k++)
         if (wr(k, s) && rem(k) > int'(u)) return 1'b1;
      return 1'b0;
   endfunction
   function automatic exp_t model(ins_t d);
      exp_t x;
      bit busy;
      busy = (cyc - md_at) >= 1 && (cyc - md_at) <= md_lat;
      x.mds = hist[0].md;
      x.mdb = busy;
      x.stall = late(d.rs, d.ur) || late(d.rt, d.ut) || (d.mu && (hist[0].md || busy));
      x.fdrs = sel(d.rs, 0, DK, 1);
      x.fdrt = sel(d.rt, 0, DK, 1);
      x.fers = sel(hist[0].rs, 1, 2, 1);
      x.fert = sel(hist[0].rt, 1, 2, 1);
      x.fmrt = sel(hist[1].rt, 2, 2, 1);
      return x;
   endfunction
   task automatic clear();
      for (int k = 0; k < 3; k++) hist[k] = '0;
      md_at = -100;
   endtask
   task automatic tick(input bit rl);
      @(posedge clk);
      if (!reset_n) clear();
      else begin
         if (hist[0].md) begin
            md_at = cyc;
            md_lat = hist[0].dv ? DIV_LAT : MULT_LAT;
         end
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = last.stall ? '0 : cur;
         if (!last.stall && cur_prog) void'(prog.pop_front());
      end
      cyc++;
      #1;
      reset_n = !rl;
      if (rl) begin
         clear();
         prog.delete();
      end
      cur_prog = prog.size() != 0;
      cur = cur_prog ? prog[0] : mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
      d_rs = cur.rs; d_rt = cur.rt; d_tuse_rs = cur.ur; d_tuse_rt = cur.ut; d_a3 = cur.a3;
      d_wen = cur.wen; d_tnew = cur.tnew; d_md_start = cur.md; d_md_div = cur.dv; d_md_use = cur.mu;
      last = model(cur);
      eq.push_back(last);
   endtask
   task automatic run_prog(input int budget);
      int n;
      n = 0;
      while (prog.size() != 0 && n < budget) begin
         tick(1'b0);
         n++;
      end
      if (prog.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d instructions left, required 0", prog.size());
         prog.delete();
      end
      repeat (3) tick(1'b0);
   endtask
   task automatic chk(string nm, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (eq.size() != 0) begin
            x = eq.pop_front();
            chk("stall", int'(stall), int'(x.stall));
            chk("fwd_d_rs", int'(fwd_d_rs), int'(x.fdrs));
            chk("fwd_d_rt", int'(fwd_d_rt), int'(x.fdrt));
            chk("fwd_e_rs", int'(fwd_e_rs), int'(x.fers));
            chk("fwd_e_rt", int'(fwd_e_rt), int'(x.fert));
            chk("fwd_m_rt", int'(fwd_m_rt), int'(x.fmrt));
            chk("md_start", int'(md_start), int'(x.mds));
            chk("md_busy", int'(md_busy), int'(x.mdb));
         end
      end
   end
   initial begin
      clear();
      cur = '0;
      cur_prog = 1'b0;
      last = '0;
      reset_n = 1'b0;
      repeat (3) tick(1'b1);
      prog.push_back(mk(1, 2, 1, 1, 3, 1, 1, 0, 0, 0));
      prog.push_back(mk(3, 5, 1, 1, 4, 1, 1, 0, 0, 0));
      prog.push_back(mk(1, 0, 1, 3, 3, 1, 2, 0, 0, 0));
      prog.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      prog.push_back(mk(0, 0, 3, 3, 31, 1, 0, 0, 0, 0));
      prog.push_back(mk(31, 0, 0, 3, 0, 0, 0, 0, 0, 0));
      prog.push_back(mk(1, 2, 1, 1, 0, 1, 1, 0, 0, 0));
      prog.push_back(mk(0, 0, 0, 0, 5, 1, 1, 0, 0, 0));
      prog.push_back(mk(1, 0, 1, 3, 2, 1, 2, 0, 0, 0));
      prog.push_back(mk(6, 2, 1, 2, 0, 0, 0, 0, 0, 0));
      prog.push_back(mk(7, 8, 1, 1, 0, 0, 0, 1, 1, 1));
      prog.push_back(mk(0, 0, 3, 3, 9, 1, 1, 0, 0, 1));
      prog.push_back(mk(7, 8, 1, 1, 0, 0, 0, 1, 0, 1));
      prog.push_back(mk(0, 0, 3, 3, 10, 1, 1, 0, 0, 1));
      run_prog(200);
      prog.push_back(mk(7, 8, 1, 1, 0, 0, 0, 1, 1, 1));
      prog.push_back(mk(0, 0, 3, 3, 9, 1, 1, 0, 0, 1));
      repeat (6) tick(1'b0);
      repeat (2) tick(1'b1);
      repeat (4) tick(1'b0);
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 500; i++) begin
            int md;
            md = ($urandom_range(0, 9) == 0) ? 1 : 0;
            prog.push_back(mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                              $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 2), md,
                              $urandom_range(0, 1), (md != 0 || $urandom_range(0, 9) == 0) ? 1 : 0));
         end
         if (b == 0) begin
            repeat (300) tick(1'b0);
            repeat (2) tick(1'b1);
         end else run_prog(20000);
      end
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
